mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (system clock; all state changes on rising edge).
REQ-002 SHALL have ports: reset input 1 (synchronous, active-high; sampled on rising clk only).
REQ-003 SHALL have ports: op input 6 (IR[31:26]); funct input 6 (IR[5:0]); zero input 1 (ALU A==B flag).
REQ-004 SHALL have ports: pc_we output 1 (PC write enable); ir_we output 1 (IR write enable); reg_we output 1 (GRF write enable); mem_we output 1 (DM write enable).
REQ-005 SHALL have ports: extop output 2 (immediate extender select: 0 zero-ext, 1 sign-ext, 2 imm<<16).
REQ-006 SHALL have ports: alu_src output 1 (0 rt data, 1 extender out); alu_op output 2 (0 ADD, 1 SUB, 2 OR).
REQ-007 SHALL have ports: reg_dst output 2 (0 rt, 1 rd, 2 $31); wd_sel output 2 (0 ALU result reg, 1 DM data reg, 2 PC).
REQ-008 SHALL have ports: npc_sel output 2 (0 PC+4, 1 branch PC+4+(sext<<2), 2 j-target, 3 rs data); state output 3 (current FSM state); done output 1 (last cycle of an instruction).

Function
REQ-009 SHALL be a 5-state FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 unused and SHALL go to FETCH next cycle.
REQ-010 SHALL decode: addu (op 0, funct 0x21), subu (op 0, funct 0x23), jr (op 0, funct 0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, jal 0x03; any other op/funct is NOP.
REQ-011 FETCH: ir_we=1, pc_we=1, npc_sel=0; next DECODE.
REQ-012 DECODE: jal -> pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2, done=1, next FETCH (PC already holds PC+4, written to $31).
REQ-013 DECODE: jr -> pc_we=1, npc_sel=3, done=1, next FETCH; NOP -> no write enable, done=1, next FETCH; all others -> EXEC.
REQ-014 EXEC: addu alu_op=0/alu_src=0; subu alu_op=1/alu_src=0; ori extop=0/alu_src=1/alu_op=2; lui extop=2/alu_src=1/alu_op=0; lw, sw extop=1/alu_src=1/alu_op=0.
REQ-015 EXEC: beq -> extop=1, alu_src=0, alu_op=1, npc_sel=1, pc_we=zero, done=1, next FETCH.
REQ-016 EXEC next: addu/subu/ori/lui -> WB; lw/sw -> MEM.
REQ-017 MEM: sw -> mem_we=1, done=1, next FETCH; lw -> no enables, next WB.
REQ-018 WB: reg_we=1; addu/subu reg_dst=1, wd_sel=0; ori/lui reg_dst=0, wd_sel=0; lw reg_dst=0, wd_sel=1; done=1; next FETCH.
REQ-019 extop, alu_src, alu_op SHALL be driven per instruction class from DECODE through the instruction's last state (stable across EXEC/MEM/WB); in FETCH all select outputs SHALL be 0.
REQ-020 Write enables and done SHALL be asserted only in the states listed above; at most one of pc_we-with-npc_sel≠0, mem_we per cycle.
REQ-021 Outputs SHALL be combinational from state, op, funct, zero; op/funct are assumed stable from DECODE until done (IR held).
REQ-022 Latencies SHALL be: jal/jr/NOP 2 cycles, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.

Reset
REQ-023 While reset=1 at a rising edge, state SHALL become FETCH, regardless of current state (including mid-instruction).
REQ-024 While reset=1 is sampled high, pc_we, ir_we, reg_we, mem_we, done SHALL be forced 0 combinationally; first cycle after reset deasserts is FETCH with ir_we=pc_we=1.

Verification
REQ-025 Reset then addu (op 0, funct 0x21): states 0,1,2,4,0; WB cycle reg_we=1, reg_dst=1, wd_sel=0, done=1.
REQ-026 lw (0x23): states 0,1,2,3,4; extop=1 from DECODE to WB; mem_we never 1; WB reg_dst=0, wd_sel=1.
REQ-027 beq with zero=1 then zero=0: EXEC pc_we=1/npc_sel=1 then pc_we=0; both 3 cycles, done=1 in EXEC.
REQ-028 lui (0x0F) and ori (0x0D): EXEC extop=2 and extop=0 respectively, alu_src=1; sw (0x2B): MEM mem_we=1, extop=1.
REQ-029 jal (0x03): DECODE pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2; next state 0; undefined op 0x3F: DECODE no enables, done=1.
REQ-030 reset=1 asserted in MEM of sw: mem_we=0 that cycle, state=0 next edge; unused state forced to 5 returns to 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: decodes op/funct and sequences the datapath enables/selects.
// Latency: jal/jr/nop 2 cycles, beq 3, sw and ALU ops 4, lw 5; outputs are combinational from state and IR fields.
// Backpressure: none; the FSM advances every clock and reset only holds it in FETCH.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic [1:0] extop,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] npc_sel,
    output logic [2:0] state,
    output logic       done
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_HIGH = 2'd2;
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;
    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MEM   = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;
    localparam logic [1:0] NPC_SEQ  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_REG  = 2'd3;

    logic [2:0] state_q;
    logic [2:0] state_nxt;
    logic       is_r;
    logic       is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
    logic       is_nop;
    logic       in_instr;
    logic       pc_we_c, ir_we_c, reg_we_c, mem_we_c, done_c;

    always_comb begin
        is_r    = (op == OP_RTYPE);
        is_addu = is_r && (funct == FN_ADDU);
        is_subu = is_r && (funct == FN_SUBU);
        is_jr   = is_r && (funct == FN_JR);
        is_ori  = (op == OP_ORI);
        is_lui  = (op == OP_LUI);
        is_lw   = (op == OP_LW);
        is_sw   = (op == OP_SW);
        is_beq  = (op == OP_BEQ);
        is_jal  = (op == OP_JAL);
        is_nop  = !(is_addu || is_subu || is_jr || is_ori || is_lui ||
                    is_lw || is_sw || is_beq || is_jal);
    end

    always_comb begin
        state_nxt = S_FETCH;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        done_c    = 1'b0;
        extop     = EXT_ZERO;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        npc_sel   = NPC_SEQ;
        in_instr  = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);

        // ALU/extender selects follow the instruction class for its whole life so
        // the datapath registers see stable operands across EXEC, MEM and WB.
        if (in_instr) begin
            if (is_subu) begin
                alu_op = ALU_SUB;
            end
            if (is_ori) begin
                extop   = EXT_ZERO;
                alu_src = 1'b1;
                alu_op  = ALU_OR;
            end
            if (is_lui) begin
                extop   = EXT_HIGH;
                alu_src = 1'b1;
            end
            if (is_lw || is_sw) begin
                extop   = EXT_SIGN;
                alu_src = 1'b1;
            end
            if (is_beq) begin
                extop  = EXT_SIGN;
                alu_op = ALU_SUB;
            end
        end

        case (state_q)
            S_FETCH: begin
                ir_we_c   = 1'b1;
                pc_we_c   = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_jal) begin
                    // PC already holds PC+4 from FETCH; that value is the link address.
                    pc_we_c  = 1'b1;
                    npc_sel  = NPC_J;
                    reg_we_c = 1'b1;
                    reg_dst  = DST_RA;
                    wd_sel   = WD_PC;
                    done_c   = 1'b1;
                end else if (is_jr) begin
                    pc_we_c = 1'b1;
                    npc_sel = NPC_REG;
                    done_c  = 1'b1;
                end else if (is_nop) begin
                    done_c = 1'b1;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    npc_sel = NPC_BR;
                    pc_we_c = zero;
                    done_c  = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    mem_we_c = 1'b1;
                    done_c   = 1'b1;
                end else if (is_lw) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                done_c   = 1'b1;
                reg_dst  = (is_addu || is_subu) ? DST_RD : DST_RT;
                wd_sel   = is_lw ? WD_MEM : WD_ALU;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign pc_we  = pc_we_c  & ~reset;
    assign ir_we  = ir_we_c  & ~reset;
    assign reg_we = reg_we_c & ~reset;
    assign mem_we = mem_we_c & ~reset;
    assign done   = done_c   & ~reset;
    assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed plus randomized instruction stream for mc_ctrl, checked cycle by cycle
// against a table-driven model of each instruction's state path and control outputs.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we, ir_we, reg_we, mem_we;
    logic [1:0] extop;
    logic       alu_src;
    logic [1:0] alu_op, reg_dst, wd_sel, npc_sel;
    logic [2:0] state;
    logic       done;

    int checks = 0;
    int errors = 0;

    localparam int C_NOP  = 0;
    localparam int C_ADDU = 1;
    localparam int C_SUBU = 2;
    localparam int C_JR   = 3;
    localparam int C_ORI  = 4;
    localparam int C_LUI  = 5;
    localparam int C_LW   = 6;
    localparam int C_SW   = 7;
    localparam int C_BEQ  = 8;
    localparam int C_JAL  = 9;

    mc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .funct   (funct),
        .zero    (zero),
        .pc_we   (pc_we),
        .ir_we   (ir_we),
        .reg_we  (reg_we),
        .mem_we  (mem_we),
        .extop   (extop),
        .alu_src (alu_src),
        .alu_op  (alu_op),
        .reg_dst (reg_dst),
        .wd_sel  (wd_sel),
        .npc_sel (npc_sel),
        .state   (state),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Field order: state, pc_we, ir_we, reg_we, mem_we, done, extop, alu_src, alu_op, reg_dst, wd_sel, npc_sel
    logic [18:0] obs;
    assign obs = {state, pc_we, ir_we, reg_we, mem_we, done, extop, alu_src,
                  alu_op, reg_dst, wd_sel, npc_sel};

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f == 6'h21) return C_ADDU;
            if (f == 6'h23) return C_SUBU;
            if (f == 6'h08) return C_JR;
            return C_NOP;
        end
        case (o)
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h03:   return C_JAL;
            default: return C_NOP;
        endcase
    endfunction

    function automatic int path_len(input int cls);
        case (cls)
            C_NOP, C_JR, C_JAL: return 2;
            C_BEQ:              return 3;
            C_LW:               return 5;
            default:            return 4;
        endcase
    endfunction

    // Instructions walk FETCH, DECODE, EXEC in order; ALU ops skip MEM and land in WB.
    function automatic logic [2:0] path_state(input int cls, input int k);
        if (k == 3 && (cls == C_ADDU || cls == C_SUBU || cls == C_ORI || cls == C_LUI))
            return 3'd4;
        return 3'(k);
    endfunction

    function automatic logic [18:0] model(input int cls, input logic z, input int k,
                                          input int len, input logic [2:0] s);
        logic       pcw = 0, irw = 0, rw = 0, mw = 0, dn;
        logic [1:0] ext = 0, aop = 0, rd = 0, wd = 0, npc = 0;
        logic       asrc = 0;
        dn = (k == len - 1);
        if (s == 3'd0) begin
            irw = 1;
            pcw = 1;
        end else begin
            case (cls)
                C_SUBU: aop = 2'd1;
                C_ORI:  begin ext = 2'd0; asrc = 1; aop = 2'd2; end
                C_LUI:  begin ext = 2'd2; asrc = 1; end
                C_LW:   begin ext = 2'd1; asrc = 1; end
                C_SW:   begin ext = 2'd1; asrc = 1; end
                C_BEQ:  begin ext = 2'd1; aop = 2'd1; end
                default: ;
            endcase
            if (cls == C_JAL && s == 3'd1) begin
                pcw = 1; npc = 2'd2; rw = 1; rd = 2'd2; wd = 2'd2;
            end
            if (cls == C_JR && s == 3'd1) begin
                pcw = 1; npc = 2'd3;
            end
            if (cls == C_BEQ && s == 3'd2) begin
                pcw = z; npc = 2'd1;
            end
            if (cls == C_SW && s == 3'd3) mw = 1;
            if (s == 3'd4) begin
                rw = 1;
                rd = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : 2'd0;
                wd = (cls == C_LW) ? 2'd1 : 2'd0;
            end
        end
        return {s, pcw, irw, rw, mw, dn, ext, asrc, aop, rd, wd, npc};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the DUT in FETCH; returns just after the
    // edge that ends the instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string name);
        int cls;
        int len;
        op    = o;
        funct = f;
        zero  = z;
        cls   = classify(o, f);
        len   = path_len(cls);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, k), obs,
                  model(cls, z, k, len, path_state(cls, k)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23,
                                6'h2B, 6'h04, 6'h03, 6'h3F, 6'h00, 6'h00};
    logic [5:0] fn_tab [12] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h2A, 6'h00};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;

        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset fetch gated", obs, {3'd0, 16'h0});
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'h00, 6'h21, 1'b0, "addu");
        run_instr(6'h23, 6'h00, 1'b0, "lw");
        run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, "beq_not_taken");
        run_instr(6'h0F, 6'h00, 1'b0, "lui");
        run_instr(6'h0D, 6'h00, 1'b0, "ori");
        run_instr(6'h2B, 6'h00, 1'b0, "sw");
        run_instr(6'h03, 6'h00, 1'b0, "jal");
        run_instr(6'h00, 6'h08, 1'b0, "jr");
        run_instr(6'h3F, 6'h00, 1'b0, "nop_op3f");
        run_instr(6'h00, 6'h23, 1'b1, "subu");
        run_instr(6'h00, 6'h2A, 1'b0, "nop_funct");

        for (int i = 0; i < 48; i++) begin
            int sel;
            logic [5:0] o;
            logic [5:0] f;
            sel = int'($urandom_range(0, 12));
            if (sel == 12) begin
                o = 6'($urandom_range(0, 63));
                f = 6'($urandom_range(0, 63));
            end else begin
                o = op_tab[sel];
                f = fn_tab[sel];
            end
            run_instr(o, f, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%02h_fn%02h", i, o, f));
        end

        // Reset landing in the MEM cycle of a store must suppress the write.
        op    = 6'h2B;
        funct = 6'h00;
        zero  = 1'b0;
        step_cycles(3);
        reset = 1'b1;
        @(negedge clk);
        check("sw mem under reset", obs,
              {3'd3, 5'b00000, 2'd1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("state after reset in mem", {16'h0, state}, {16'h0, 3'd0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'h00, 6'h21, 1'b0, "addu_after_reset");

        // Drive the state register into an unused encoding from the WB cycle of an addu.
        op    = 6'h00;
        funct = 6'h21;
        step_cycles(3);
        force dut.state_q = 3'd5;
        @(negedge clk);
        check("unused state outputs", obs, {3'd5, 16'h0});
        release dut.state_q;
        @(posedge clk);
        #1;
        run_instr(6'h23, 6'h00, 1'b0, "lw_after_unused");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
